// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths, field slices, status layout and miss FSM encoding for the icache
package icache_pkg;

    localparam int META_W        = 16;
    localparam int WAYS          = 4;
    localparam int TAG_W         = 8;
    localparam int SET_W         = 4;
    localparam int WAY_W         = 2;
    localparam int STATUS_W      = 2 * WAYS;
    localparam int REFILL_ADDR_W = TAG_W + SET_W;

    localparam int META_TAG_LSB  = 8;
    localparam int META_SET_LSB  = 4;
    localparam int META_OFF_LSB  = 0;

    // Each way owns a bit pair in the status word: {used, valid}.
    localparam int ST_VALID      = 0;
    localparam int ST_USED       = 1;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_REQ    = 2'd1,
        MS_UPDATE = 2'd2
    } miss_state_e;

    function automatic logic [TAG_W-1:0] meta_tag(input logic [META_W-1:0] md);
        return md[META_TAG_LSB +: TAG_W];
    endfunction

    function automatic logic [SET_W-1:0] meta_set(input logic [META_W-1:0] md);
        return md[META_SET_LSB +: SET_W];
    endfunction

endpackage

// File: rtl/icache_nru_policy.sv
// rtl/icache_nru_policy.sv - NRU status update for a touched way plus victim selection
module icache_nru_policy
    import icache_pkg::*;
(
    input  logic [STATUS_W-1:0] i_status,
    input  logic [WAY_W-1:0]    i_way,
    output logic [STATUS_W-1:0] o_status,
    output logic [WAY_W-1:0]    o_victim
);

    logic [WAYS-1:0] valid;
    logic [WAYS-1:0] used;
    logic [WAYS-1:0] new_valid;
    logic [WAYS-1:0] new_used;

    always_comb begin
        valid = '0;
        used  = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid[w] = i_status[2*w + ST_VALID];
            used[w]  = i_status[2*w + ST_USED];
        end

        new_valid        = valid;
        new_used         = used;
        new_valid[i_way] = 1'b1;
        new_used[i_way]  = 1'b1;
        // Once every way looks recently used, only the touched way keeps its mark.
        if (&new_used) begin
            new_used        = '0;
            new_used[i_way] = 1'b1;
        end

        o_status = '0;
        for (int w = 0; w < WAYS; w++) begin
            o_status[2*w + ST_VALID] = new_valid[w];
            o_status[2*w + ST_USED]  = new_used[w];
        end

        o_victim = '0;
        if (!(&valid)) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!valid[w]) o_victim = WAY_W'(w);
            end
        end else if (!(&used)) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!used[w]) o_victim = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/icache_stage2.sv
// rtl/icache_stage2.sv - icache tag compare, NRU update and line-miss refill FSM
module icache_stage2
    import icache_pkg::*;
#(
    parameter int METADATA_WIDTH = META_W,
    parameter int NUM_WAYS       = WAYS,
    parameter int TAG_WIDTH      = TAG_W,
    parameter int SET_BITS_WIDTH = SET_W
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            i_halt,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]   i_ta_data,
    input  logic                            i_ta_data_valid,
    input  logic [2*NUM_WAYS-1:0]           i_sa_data,
    input  logic                            i_sa_data_valid,
    input  logic [METADATA_WIDTH-1:0]       i_metadata,
    input  logic                            i_metadata_valid,
    input  logic                            i_refill_ack,
    output logic                            o_valid,
    output logic                            o_hit,
    output logic [1:0]                      o_hit_way,
    output logic [METADATA_WIDTH-1:0]       o_metadata,
    output logic                            o_miss_state,
    output logic                            o_refill_req,
    output logic [TAG_WIDTH+SET_BITS_WIDTH-1:0] o_refill_addr,
    output logic [SET_BITS_WIDTH-1:0]       o_w_ta_set_addr,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]   o_w_ta_data,
    output logic [NUM_WAYS-1:0]             o_w_ta_mask,
    output logic                            o_w_ta_valid,
    output logic [SET_BITS_WIDTH-1:0]       o_w_sa_set_addr,
    output logic [2*NUM_WAYS-1:0]           o_w_sa_data,
    output logic [NUM_WAYS-1:0]             o_w_sa_mask,
    output logic                            o_w_sa_valid,
    output logic                            o_ready
);

    miss_state_e        state_q, state_d;
    logic               valid_q, valid_d;
    logic               hit_q, hit_d;
    logic [WAY_W-1:0]   hit_way_q, hit_way_d;
    logic [META_W-1:0]  meta_q, meta_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [SET_W-1:0]   miss_set_q, miss_set_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [STATUS_W-1:0] miss_status_q, miss_status_d;
    logic               ack_pend_q, ack_pend_d;
    logic [SET_W-1:0]   w_ta_set_q, w_ta_set_d;
    logic [WAYS*TAG_W-1:0] w_ta_data_q, w_ta_data_d;
    logic [WAYS-1:0]    w_ta_mask_q, w_ta_mask_d;
    logic               w_ta_valid_q, w_ta_valid_d;
    logic [SET_W-1:0]   w_sa_set_q, w_sa_set_d;
    logic [STATUS_W-1:0] w_sa_data_q, w_sa_data_d;
    logic [WAYS-1:0]    w_sa_mask_q, w_sa_mask_d;
    logic               w_sa_valid_q, w_sa_valid_d;
    logic               byp_valid_q, byp_valid_d;
    logic [SET_W-1:0]   byp_set_q, byp_set_d;
    logic [STATUS_W-1:0] byp_data_q, byp_data_d;

    logic               accept;
    logic [TAG_W-1:0]   req_tag;
    logic [SET_W-1:0]   req_set;
    logic [STATUS_W-1:0] sa_eff;
    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [STATUS_W-1:0] nru_status_in;
    logic [WAY_W-1:0]   nru_way_in;
    logic [STATUS_W-1:0] nru_status;
    logic [WAY_W-1:0]   nru_victim;

    assign accept  = i_metadata_valid & i_ta_data_valid & i_sa_data_valid
                   & (state_q == MS_IDLE) & ~i_halt;
    assign req_tag = meta_tag(i_metadata);
    assign req_set = meta_set(i_metadata);

    // The array read for this request predates the two most recent status writes;
    // the newest matching write wins.
    always_comb begin
        sa_eff = i_sa_data;
        if (byp_valid_q && (byp_set_q == req_set)) sa_eff = byp_data_q;
        if (w_sa_valid_q && (w_sa_set_q == req_set)) sa_eff = w_sa_data_q;
    end

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = sa_eff[2*w + ST_VALID] & (i_ta_data[w*TAG_W +: TAG_W] == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end
    assign hit = |hit_vec;

    assign nru_status_in = (state_q == MS_IDLE) ? sa_eff  : miss_status_q;
    assign nru_way_in    = (state_q == MS_IDLE) ? hit_way : victim_q;

    icache_nru_policy u_nru (
        .i_status (nru_status_in),
        .i_way    (nru_way_in),
        .o_status (nru_status),
        .o_victim (nru_victim)
    );

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        hit_d         = hit_q;
        hit_way_d     = hit_way_q;
        meta_d        = meta_q;
        miss_tag_d    = miss_tag_q;
        miss_set_d    = miss_set_q;
        victim_d      = victim_q;
        miss_status_d = miss_status_q;
        ack_pend_d    = ack_pend_q;
        w_ta_set_d    = w_ta_set_q;
        w_ta_data_d   = w_ta_data_q;
        w_ta_mask_d   = w_ta_mask_q;
        w_ta_valid_d  = w_ta_valid_q;
        w_sa_set_d    = w_sa_set_q;
        w_sa_data_d   = w_sa_data_q;
        w_sa_mask_d   = w_sa_mask_q;
        w_sa_valid_d  = w_sa_valid_q;
        byp_valid_d   = byp_valid_q;
        byp_set_d     = byp_set_q;
        byp_data_d    = byp_data_q;

        if (i_halt) begin
            if ((state_q == MS_REQ) && i_refill_ack) ack_pend_d = 1'b1;
        end else begin
            valid_d      = 1'b0;
            w_ta_valid_d = 1'b0;
            w_sa_valid_d = 1'b0;
            byp_valid_d  = w_sa_valid_q;
            byp_set_d    = w_sa_set_q;
            byp_data_d   = w_sa_data_q;
            unique case (state_q)
                MS_IDLE: begin
                    if (accept) begin
                        valid_d = 1'b1;
                        hit_d   = hit;
                        meta_d  = i_metadata;
                        if (hit) begin
                            hit_way_d    = hit_way;
                            w_sa_valid_d = 1'b1;
                            w_sa_set_d   = req_set;
                            w_sa_data_d  = nru_status;
                            w_sa_mask_d  = '1;
                        end else begin
                            hit_way_d     = nru_victim;
                            victim_d      = nru_victim;
                            miss_tag_d    = req_tag;
                            miss_set_d    = req_set;
                            miss_status_d = sa_eff;
                            state_d       = MS_REQ;
                        end
                    end
                end
                MS_REQ: begin
                    if (i_refill_ack || ack_pend_q) begin
                        ack_pend_d   = 1'b0;
                        state_d      = MS_UPDATE;
                        w_ta_valid_d = 1'b1;
                        w_ta_set_d   = miss_set_q;
                        w_ta_data_d  = {WAYS{miss_tag_q}};
                        w_ta_mask_d  = WAYS'(1) << victim_q;
                        w_sa_valid_d = 1'b1;
                        w_sa_set_d   = miss_set_q;
                        w_sa_data_d  = nru_status;
                        w_sa_mask_d  = '1;
                    end
                end
                MS_UPDATE: begin
                    ack_pend_d = 1'b0;
                    state_d    = MS_IDLE;
                end
                default: state_d = MS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= MS_IDLE;
            valid_q       <= 1'b0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            meta_q        <= '0;
            miss_tag_q    <= '0;
            miss_set_q    <= '0;
            victim_q      <= '0;
            miss_status_q <= '0;
            ack_pend_q    <= 1'b0;
            w_ta_set_q    <= '0;
            w_ta_data_q   <= '0;
            w_ta_mask_q   <= '0;
            w_ta_valid_q  <= 1'b0;
            w_sa_set_q    <= '0;
            w_sa_data_q   <= '0;
            w_sa_mask_q   <= '0;
            w_sa_valid_q  <= 1'b0;
            byp_valid_q   <= 1'b0;
            byp_set_q     <= '0;
            byp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            hit_q         <= hit_d;
            hit_way_q     <= hit_way_d;
            meta_q        <= meta_d;
            miss_tag_q    <= miss_tag_d;
            miss_set_q    <= miss_set_d;
            victim_q      <= victim_d;
            miss_status_q <= miss_status_d;
            ack_pend_q    <= ack_pend_d;
            w_ta_set_q    <= w_ta_set_d;
            w_ta_data_q   <= w_ta_data_d;
            w_ta_mask_q   <= w_ta_mask_d;
            w_ta_valid_q  <= w_ta_valid_d;
            w_sa_set_q    <= w_sa_set_d;
            w_sa_data_q   <= w_sa_data_d;
            w_sa_mask_q   <= w_sa_mask_d;
            w_sa_valid_q  <= w_sa_valid_d;
            byp_valid_q   <= byp_valid_d;
            byp_set_q     <= byp_set_d;
            byp_data_q    <= byp_data_d;
        end
    end

    assert property (@(posedge clk) disable iff (!arst_n) accept |-> $onehot0(hit_vec))
        else $fatal(1, "icache_stage2: multiple ways hit");

    // Pulses are masked while halted so each one reaches the arrays in exactly one live cycle.
    assign o_valid         = valid_q & ~i_halt;
    assign o_hit           = hit_q;
    assign o_hit_way       = hit_way_q;
    assign o_metadata      = meta_q;
    assign o_miss_state    = (state_q != MS_IDLE);
    assign o_refill_req    = (state_q == MS_REQ);
    assign o_refill_addr   = {miss_tag_q, miss_set_q};
    assign o_w_ta_set_addr = w_ta_set_q;
    assign o_w_ta_data     = w_ta_data_q;
    assign o_w_ta_mask     = w_ta_mask_q;
    assign o_w_ta_valid    = w_ta_valid_q & ~i_halt;
    assign o_w_sa_set_addr = w_sa_set_q;
    assign o_w_sa_data     = w_sa_data_q;
    assign o_w_sa_mask     = w_sa_mask_q;
    assign o_w_sa_valid    = w_sa_valid_q & ~i_halt;
    assign o_ready         = arst_n & ~i_halt & (state_q == MS_IDLE);

endmodule

// File: tb/tb_icache_stage2.sv
// tb/tb_icache_stage2.sv - directed self-checking bench for icache_stage2
module tb_icache_stage2;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_halt;
    logic [31:0] i_ta_data;
    logic        i_ta_data_valid;
    logic [7:0]  i_sa_data;
    logic        i_sa_data_valid;
    logic [15:0] i_metadata;
    logic        i_metadata_valid;
    logic        i_refill_ack;
    logic        o_valid;
    logic        o_hit;
    logic [1:0]  o_hit_way;
    logic [15:0] o_metadata;
    logic        o_miss_state;
    logic        o_refill_req;
    logic [11:0] o_refill_addr;
    logic [3:0]  o_w_ta_set_addr;
    logic [31:0] o_w_ta_data;
    logic [3:0]  o_w_ta_mask;
    logic        o_w_ta_valid;
    logic [3:0]  o_w_sa_set_addr;
    logic [7:0]  o_w_sa_data;
    logic [3:0]  o_w_sa_mask;
    logic        o_w_sa_valid;
    logic        o_ready;

    int checks   = 0;
    int failures = 0;

    icache_stage2 dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_halt           (i_halt),
        .i_ta_data        (i_ta_data),
        .i_ta_data_valid  (i_ta_data_valid),
        .i_sa_data        (i_sa_data),
        .i_sa_data_valid  (i_sa_data_valid),
        .i_metadata       (i_metadata),
        .i_metadata_valid (i_metadata_valid),
        .i_refill_ack     (i_refill_ack),
        .o_valid          (o_valid),
        .o_hit            (o_hit),
        .o_hit_way        (o_hit_way),
        .o_metadata       (o_metadata),
        .o_miss_state     (o_miss_state),
        .o_refill_req     (o_refill_req),
        .o_refill_addr    (o_refill_addr),
        .o_w_ta_set_addr  (o_w_ta_set_addr),
        .o_w_ta_data      (o_w_ta_data),
        .o_w_ta_mask      (o_w_ta_mask),
        .o_w_ta_valid     (o_w_ta_valid),
        .o_w_sa_set_addr  (o_w_sa_set_addr),
        .o_w_sa_data      (o_w_sa_data),
        .o_w_sa_mask      (o_w_sa_mask),
        .o_w_sa_valid     (o_w_sa_valid),
        .o_ready          (o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] ta, input logic [7:0] sa, input logic [15:0] md);
        i_ta_data        = ta;
        i_sa_data        = sa;
        i_metadata       = md;
        i_ta_data_valid  = 1'b1;
        i_sa_data_valid  = 1'b1;
        i_metadata_valid = 1'b1;
    endtask

    task automatic no_req();
        i_ta_data_valid  = 1'b0;
        i_sa_data_valid  = 1'b0;
        i_metadata_valid = 1'b0;
    endtask

    initial begin
        arst_n       = 1'b0;
        i_halt       = 1'b0;
        i_refill_ack = 1'b0;
        i_ta_data    = '0;
        i_sa_data    = '0;
        i_metadata   = '0;
        no_req();
        step();
        step();
        chk("rst_valid",     32'(o_valid), 32'h0);
        chk("rst_refill",    32'(o_refill_req), 32'h0);
        chk("rst_miss",      32'(o_miss_state), 32'h0);
        chk("rst_strobes",   32'({o_w_ta_valid, o_w_sa_valid}), 32'h0);
        chk("rst_ready",     32'(o_ready), 32'h0);
        arst_n = 1'b1;
        step();
        chk("rel_ready",     32'(o_ready), 32'h1);

        // hit on way 2, set 5
        req(32'h11AB3344, 8'h3F, 16'hAB53);
        step();
        no_req();
        chk("hit_valid",     32'(o_valid), 32'h1);
        chk("hit_flag",      32'(o_hit), 32'h1);
        chk("hit_way",       32'(o_hit_way), 32'h2);
        chk("hit_meta",      32'(o_metadata), 32'hAB53);
        chk("hit_sa_valid",  32'(o_w_sa_valid), 32'h1);
        chk("hit_sa_set",    32'(o_w_sa_set_addr), 32'h5);
        chk("hit_sa_data",   32'(o_w_sa_data), 32'h3F);
        chk("hit_sa_mask",   32'(o_w_sa_mask), 32'hF);
        chk("hit_ta_valid",  32'(o_w_ta_valid), 32'h0);
        step();
        chk("hit_pulse",     32'({o_valid, o_w_sa_valid}), 32'h0);

        // back-to-back hits to set 3 through the status bypass
        req(32'h40302010, 8'h55, 16'h1030);
        step();
        chk("b2b0_way",      32'(o_hit_way), 32'h0);
        chk("b2b0_sa_data",  32'(o_w_sa_data), 32'h57);
        req(32'h40302010, 8'h55, 16'h2030);
        step();
        no_req();
        chk("b2b1_valid",    32'(o_valid), 32'h1);
        chk("b2b1_hit",      32'(o_hit), 32'h1);
        chk("b2b1_way",      32'(o_hit_way), 32'h1);
        chk("b2b1_sa_data",  32'(o_w_sa_data), 32'h5F);
        step();

        // cold miss, way 1 invalid
        req(32'h44332211, 8'h31, 16'h7724);
        step();
        no_req();
        chk("cold_valid",    32'(o_valid), 32'h1);
        chk("cold_hit",      32'(o_hit), 32'h0);
        chk("cold_victim",   32'(o_hit_way), 32'h1);
        chk("cold_req",      32'(o_refill_req), 32'h1);
        chk("cold_addr",     32'(o_refill_addr), 32'h772);
        chk("cold_ready",    32'(o_ready), 32'h0);
        repeat (6) step();
        chk("cold_wait_req", 32'(o_refill_req), 32'h1);
        chk("cold_wait_wr",  32'({o_w_ta_valid, o_w_sa_valid}), 32'h0);
        i_refill_ack = 1'b1;
        step();
        i_refill_ack = 1'b0;
        chk("cold_ta_valid", 32'(o_w_ta_valid), 32'h1);
        chk("cold_ta_mask",  32'(o_w_ta_mask), 32'h2);
        chk("cold_ta_data",  o_w_ta_data, 32'h77777777);
        chk("cold_ta_set",   32'(o_w_ta_set_addr), 32'h2);
        chk("cold_sa_valid", 32'(o_w_sa_valid), 32'h1);
        chk("cold_sa_data",  32'(o_w_sa_data), 32'h3D);
        chk("cold_sa_set",   32'(o_w_sa_set_addr), 32'h2);
        chk("cold_upd_req",  32'(o_refill_req), 32'h0);
        step();
        chk("cold_idle",     32'({o_miss_state, o_w_ta_valid, o_w_sa_valid}), 32'h0);
        chk("cold_ready2",   32'(o_ready), 32'h1);

        // full set, way 0 is the only unused way
        req(32'h44332211, 8'hFD, 16'h9910);
        step();
        no_req();
        chk("full_hit",      32'(o_hit), 32'h0);
        chk("full_victim",   32'(o_hit_way), 32'h0);
        step();
        i_refill_ack = 1'b1;
        step();
        i_refill_ack = 1'b0;
        chk("full_ta_mask",  32'(o_w_ta_mask), 32'h1);
        chk("full_ta_data",  o_w_ta_data, 32'h99999999);
        chk("full_sa_data",  32'(o_w_sa_data), 32'h57);
        step();

        // halt during REQ with an ack while halted; a request during REQ is dropped
        req(32'h44332211, 8'h00, 16'h5560);
        step();
        chk("halt_victim",   32'(o_hit_way), 32'h0);
        req(32'h40302010, 8'h55, 16'h2030);
        step();
        no_req();
        chk("drop_valid",    32'(o_valid), 32'h0);
        chk("drop_meta",     32'(o_metadata), 32'h5560);
        chk("drop_ready",    32'(o_ready), 32'h0);
        i_halt       = 1'b1;
        i_refill_ack = 1'b1;
        step();
        i_refill_ack = 1'b0;
        step();
        chk("halt_state",    32'({o_miss_state, o_refill_req}), 32'h3);
        chk("halt_no_wr",    32'({o_w_ta_valid, o_w_sa_valid}), 32'h0);
        chk("halt_ready",    32'(o_ready), 32'h0);
        i_halt = 1'b0;
        step();
        chk("halt_upd_ta",   32'(o_w_ta_valid), 32'h1);
        chk("halt_upd_mask", 32'(o_w_ta_mask), 32'h1);
        chk("halt_upd_sa",   32'(o_w_sa_data), 32'h03);
        step();
        chk("halt_once_a",   32'({o_miss_state, o_w_ta_valid, o_w_sa_valid}), 32'h0);
        step();
        chk("halt_once_b",   32'({o_miss_state, o_w_ta_valid, o_w_sa_valid}), 32'h0);

        // reset in the middle of a refill
        req(32'h44332211, 8'h55, 16'h6670);
        step();
        no_req();
        step();
        chk("mid_req",       32'(o_refill_req), 32'h1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_fsm",   32'({o_miss_state, o_refill_req}), 32'h0);
        chk("mid_rst_addr",  32'(o_refill_addr), 32'h0);
        chk("mid_rst_meta",  32'(o_metadata), 32'h0);
        chk("mid_rst_ta",    o_w_ta_data, 32'h0);
        chk("mid_rst_ready", 32'(o_ready), 32'h0);
        step();
        arst_n = 1'b1;
        step();
        chk("mid_rel_ready", 32'(o_ready), 32'h1);
        chk("mid_rel_miss",  32'(o_miss_state), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
